// File: rtl/match_tally_pkg.sv
// Shared types and constants for the match tally block.
package match_tally_pkg;

    localparam logic [1:0] RES_A    = 2'd0;
    localparam logic [1:0] RES_B    = 2'd1;
    localparam logic [1:0] RES_DRAW = 2'd2;

    localparam int unsigned REPORT_WORDS = 6;

    localparam logic [7:0]  WIN_MAX = 8'hFF;
    localparam logic [15:0] RUN_MAX = 16'hFFFF;

    typedef enum logic {
        StIdle,
        StReport
    } state_e;

    typedef struct packed {
        logic [7:0]  wins_a;
        logic [7:0]  wins_b;
        logic [7:0]  draws;
        logic [15:0] runs_a;
        logic [15:0] runs_b;
        logic        err;
        logic [7:0]  max_streak;
    } stats_t;

endpackage

// File: rtl/match_tally_if.sv
// Match input and report output bundle for match_tally.
interface match_tally_if;

    logic        in_valid;
    logic [7:0]  score_A;
    logic [7:0]  score_B;
    logic [1:0]  result;
    logic        query;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;

    modport master (
        output in_valid, score_A, score_B, result, query,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, score_A, score_B, result, query,
        output out_valid, out_data, busy
    );

endinterface

// File: rtl/sat_add.sv
// Unsigned addition clamped to all-ones on overflow.
module sat_add #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] sum_o
);

    logic [Width:0] full;

    always_comb begin
        full  = {1'b0, a_i} + {1'b0, b_i};
        sum_o = full[Width] ? {Width{1'b1}} : full[Width-1:0];
    end

endmodule

// File: rtl/match_tally.sv
// Accumulates legal match results and streaks; emits a six-word snapshot report on query.
module match_tally
    import match_tally_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    match_tally_if.slave  bus
);

    stats_t     stats_q, stats_d, snap_q, snap_d;
    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       team_q, team_d;  // 0: Team A holds the streak
    logic [7:0] cur_len_q, cur_len_d;

    logic       legal, win_a, win_b, draw;
    logic [7:0] wins_a_sum, wins_b_sum, draws_sum, len_inc;
    logic [15:0] runs_a_sum, runs_b_sum;

    always_comb begin
        legal = 1'b0;
        if (bus.in_valid) begin
            case (bus.result)
                RES_A:    legal = bus.score_A > bus.score_B;
                RES_B:    legal = bus.score_B > bus.score_A;
                RES_DRAW: legal = bus.score_A == bus.score_B;
                default:  legal = 1'b0;
            endcase
        end
        win_a = legal && (bus.result == RES_A);
        win_b = legal && (bus.result == RES_B);
        draw  = legal && (bus.result == RES_DRAW);
    end

    sat_add #(.Width(8)) u_wins_a (
        .a_i(stats_q.wins_a), .b_i({7'd0, win_a}), .sum_o(wins_a_sum)
    );
    sat_add #(.Width(8)) u_wins_b (
        .a_i(stats_q.wins_b), .b_i({7'd0, win_b}), .sum_o(wins_b_sum)
    );
    sat_add #(.Width(8)) u_draws (
        .a_i(stats_q.draws), .b_i({7'd0, draw}), .sum_o(draws_sum)
    );
    sat_add #(.Width(16)) u_runs_a (
        .a_i(stats_q.runs_a), .b_i(legal ? {8'd0, bus.score_A} : 16'd0), .sum_o(runs_a_sum)
    );
    sat_add #(.Width(16)) u_runs_b (
        .a_i(stats_q.runs_b), .b_i(legal ? {8'd0, bus.score_B} : 16'd0), .sum_o(runs_b_sum)
    );
    sat_add #(.Width(8)) u_streak (
        .a_i(cur_len_q), .b_i(8'd1), .sum_o(len_inc)
    );

    always_comb begin
        team_d    = team_q;
        cur_len_d = cur_len_q;
        if (win_a) begin
            cur_len_d = (team_q == 1'b0) ? len_inc : 8'd1;
            team_d    = 1'b0;
        end else if (win_b) begin
            cur_len_d = (team_q == 1'b1) ? len_inc : 8'd1;
            team_d    = 1'b1;
        end else if (draw) begin
            cur_len_d = 8'd0;
        end

        stats_d            = stats_q;
        stats_d.wins_a     = wins_a_sum;
        stats_d.wins_b     = wins_b_sum;
        stats_d.draws      = draws_sum;
        stats_d.runs_a     = runs_a_sum;
        stats_d.runs_b     = runs_b_sum;
        stats_d.err        = stats_q.err | (bus.in_valid && !legal);
        stats_d.max_streak = (cur_len_d > stats_q.max_streak) ? cur_len_d : stats_q.max_streak;
    end

    // Snapshot takes the pre-edge stats so a same-cycle match lands only in the live counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        unique case (state_q)
            StIdle: begin
                if (bus.query) begin
                    state_d = StReport;
                    idx_d   = 3'd0;
                    snap_d  = stats_q;
                end
            end
            StReport: begin
                if (idx_q == 3'(REPORT_WORDS - 1)) begin
                    state_d = StIdle;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == StReport);
        bus.busy      = (state_q == StReport);
        bus.out_data  = 16'd0;
        if (state_q == StReport) begin
            case (idx_q)
                3'd0:    bus.out_data = {8'd0, snap_q.wins_a};
                3'd1:    bus.out_data = {8'd0, snap_q.wins_b};
                3'd2:    bus.out_data = {8'd0, snap_q.draws};
                3'd3:    bus.out_data = snap_q.runs_a;
                3'd4:    bus.out_data = snap_q.runs_b;
                3'd5:    bus.out_data = {snap_q.err, 7'd0, snap_q.max_streak};
                default: bus.out_data = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            stats_q   <= '0;
            snap_q    <= '0;
            team_q    <= 1'b0;
            cur_len_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stats_q   <= stats_d;
            snap_q    <= snap_d;
            team_q    <= team_d;
            cur_len_q <= cur_len_d;
        end
    end

endmodule

// File: doc/match_tally.md
MATCH_TALLY -- requirements
Module: match_tally

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have in_valid input 1: a match result is present, driven by the scorer's out_valid.
REQ-003 The block SHALL have score_A input 8: Team A final score, sampled when in_valid=1.
REQ-004 The block SHALL have score_B input 8: Team B final score, sampled when in_valid=1.
REQ-005 The block SHALL have result input 2: 0 A wins, 1 B wins, 2 draw, 3 illegal.
REQ-006 The block SHALL have query input 1: single-cycle report request.
REQ-007 The block SHALL have out_valid output 1: high only while a report word is on out_data.
REQ-008 The block SHALL have out_data output 16: report word, zero-extended where the field is narrower.
REQ-009 The block SHALL have busy output 1: high while in REPORT state.

Function
REQ-010 The block SHALL accept one match on every cycle in which in_valid=1, including back-to-back cycles and cycles during REPORT.
REQ-011 The block SHALL accept a match only if it is legal: result=0 needs A>B, result=1 needs B>A, result=2 needs A==B, and result=3 is illegal; an illegal match SHALL change no counter and SHALL set the sticky err flag.
REQ-012 An accepted match SHALL increment exactly one of wins_A, wins_B, draws; each is 8-bit and saturates at 255.
REQ-013 An accepted match SHALL add score_A to runs_A and score_B to runs_B; each is 16-bit and saturates at 65535, including when the addend would exceed the remaining headroom.
REQ-014 Streak tracking SHALL work as follows: a win by the current streak team increments cur_len (saturating at 255); a win by the other team sets the team and cur_len=1; a draw clears cur_len to 0; max_streak (8-bit) SHALL become max(max_streak, new cur_len) in the same cycle.
REQ-015 The FSM SHALL have states IDLE and REPORT; IDLE goes to REPORT on query=1; REPORT returns to IDLE after word 5; query while in REPORT SHALL be ignored.
REQ-016 On query acceptance the block SHALL snapshot all statistics as they stood before that edge; a match arriving in the same cycle SHALL be counted but excluded from that report.
REQ-017 out_valid SHALL rise the cycle after query is sampled and stay high for exactly 6 consecutive cycles, emitting words 0..5: wins_A, wins_B, draws, runs_A, runs_B, {err, 7'b0, max_streak}.
REQ-018 Statistics SHALL never clear except on reset; the report SHALL NOT modify them.

Reset
REQ-019 While rst_n=0, out_valid, out_data and busy SHALL be 0 and the FSM SHALL be in IDLE, regardless of the clock.
REQ-020 Reset SHALL clear all counters, the streak state, max_streak, the snapshot and err to 0.
REQ-021 Reset asserted mid-report SHALL abort the report immediately, with out_valid 0 in the same instant.
REQ-022 After rst_n deasserts, the first in_valid or query SHALL be honoured on the next rising edge.

Structure
REQ-023 A shared package SHALL hold the result codes (RES_A=0, RES_B=1, RES_DRAW=2), REPORT_WORDS=6, the FSM state enum, and the saturation limits.
REQ-024 One sub-module, sat_add, SHALL implement parameterised-width saturating addition and SHALL be reused for the win, run and streak counters.
REQ-025 The word index SHALL be a 3-bit counter; no other storage is needed beyond the counters and the snapshot.

Verification
REQ-026 Bench SHALL cover: reset; matches (3,1,0), (2,5,1), (4,4,2); query -> words 1,1,1,9,10,0x0001.
REQ-027 Bench SHALL cover: four A wins back-to-back, one B win, then query -> word0=4, word5=0x0004.
REQ-028 Bench SHALL cover: match (2,3,0) then (1,1,3), then query -> all counts 0, word5=0x8000.
REQ-029 Bench SHALL cover: 300 legal A wins of (255,0,0) -> wins_A=255, runs_A=65535, max_streak=255.
REQ-030 Bench SHALL cover: query on the same cycle as match (1,0,0) on empty stats -> report all zero; a second query -> word0=1; query during REPORT -> exactly 6 words.
REQ-031 Bench SHALL cover: rst_n pulsed low during word 3 -> out_valid 0 immediately, and a subsequent query reports zeros.
